apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Upstream APB requester that turns a simple valid/ready command stream into APB3/APB4 transfers.
- Issues one transfer at a time using the SETUP/ACCESS protocol, waits on PREADY, then returns read data and error status on a valid/ready response channel.
- Drives PSEL, PENABLE, PADDR and related signals directly into the APB slave register block.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 8, width of the write data, read data and PRDATA paths.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; used only when APB_MASTER_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_prot  in  3  protection attribute, forwarded to PPROT.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  PSLVERR, or timeout when APB_MASTER_TIMEOUT_EN is defined.
- PADDR  out  ADDR_WIDTH  APB address.
- PPROT  out  3  APB protection.
- PNSE  out  1  tied to 0 at all times.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: clock is PCLK; reset is synchronous and active-high (PRESET).
  - While PRESET is high at a rising edge, the state goes to IDLE.
  - All of the following reset to 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PPROT, rsp_valid, rsp_rdata, rsp_err.
  - cmd_ready = (state==IDLE) && !PRESET; it is combinational and 0 during reset.
- Reset mid-transfer: the transfer is abandoned. PSEL and PENABLE are 0 after the reset edge and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch cmd_addr, cmd_write, cmd_wdata and cmd_prot into PADDR, PWRITE, PWDATA and PPROT. Next state is SETUP, with PSEL=1 and PENABLE=0.
  - SETUP: lasts exactly one cycle. Next state is ACCESS, with PSEL=1 and PENABLE=1.
  - ACCESS: hold all APB outputs stable.
  - ACCESS with PREADY=1 at an edge:
    - Capture rsp_rdata = PWRITE ? 0 : PRDATA.
    - Capture rsp_err = PSLVERR.
    - Drive PSEL=0, PENABLE=0 and rsp_valid=1, then go to RESP.
  - ACCESS with PREADY=0: stay in ACCESS (wait state).
  - RESP: hold rsp_valid, rsp_rdata and rsp_err until rsp_valid && rsp_ready at an edge. Then rsp_valid=0 and the next state is IDLE.
- Outputs are all registered except cmd_ready and busy.
- PADDR, PWRITE, PWDATA and PPROT keep their last values in IDLE and RESP, and change only on command accept.
- Latency: command accepted at edge N gives:
  - SETUP during cycle N+1.
  - First ACCESS cycle at N+2.
  - With zero wait states, rsp_valid=1 from edge N+3.
  - Each PREADY-low cycle adds one cycle.
- Throughput: one outstanding transfer. The minimum command-to-command spacing is 4 cycles (zero wait states, rsp_ready held high).
- cmd_valid while not in IDLE is ignored and not accepted; the command source must hold it.
- PSLVERR is sampled only when PREADY=1 in ACCESS.
- PREADY, PRDATA and PSLVERR are ignored in IDLE, SETUP and RESP.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - If PREADY=0 and the counter equals TIMEOUT_CYCLES-1, the transfer aborts at that edge: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, and the next state is RESP.
  - If PREADY=1 on that same cycle, it completes normally; PREADY takes priority over the timeout.
- Not defined: no counter logic exists, ACCESS waits indefinitely for PREADY, and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset behaviour: assert PRESET for 3 cycles during an ACCESS wait state -> PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=0 during reset; cmd_ready=1 on the first cycle after release.
- Zero-wait write: cmd_addr=0x0000_0008, cmd_wdata=0xA5, cmd_write=1, PREADY tied 1, rsp_ready=1 -> PSEL rises at N+1, PENABLE at N+2, PWDATA=0xA5 held both cycles; rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0x00.
- Read with 3 wait states: addr 0x08, PREADY low for 3 ACCESS cycles then high with PRDATA=0x5C -> ACCESS lasts 4 cycles; rsp_rdata=0x5C, rsp_err=0, all APB outputs stable throughout.
- Slave error with response backpressure: PSLVERR=1 when PREADY=1, rsp_ready low for 5 cycles -> rsp_err=1, rsp_valid held 5 cycles, cmd_ready=0 until the response handshake, then 1 the next cycle.
- Back-to-back commands: 2 writes queued with cmd_valid continuously high and zero wait states -> second command accepted exactly 4 cycles after the first.
- Timeout (APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4): PREADY held 0 -> abort after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=0. Repeat with PREADY=1 on the 4th cycle -> normal completion with rsp_err=PSLVERR.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB3/APB4 requester: valid/ready command in, one SETUP/ACCESS transfer, valid/ready response out.
// Optional ACCESS-phase timeout abort when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [2:0]            PPROT,
  output logic                  PNSE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]            wait_cnt_q, wait_cnt_d;
`endif

  assign cmd_ready = (state_q == IDLE) && !PRESET;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pprot_d     = pprot_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          pprot_d   = cmd_prot;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        // PREADY wins over a timeout landing on the same cycle
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PPROT     = pprot_q;
  assign PNSE      = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
